// File: rtl/dout_pkg.sv
// Shared definitions for the dut result stream and the output pair packer.
package dout_pkg;

    localparam int unsigned W_RES = 11;

    typedef logic [W_RES-1:0] result_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HAVE_ONE = 2'd1,
        OUT      = 2'd2
    } pk_state_t;

endpackage

// File: rtl/pkr_fifo.sv
// Small synchronous FIFO with a registered occupancy count and registered full/empty flags.
module pkr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dout_pair_packer.sv
// Buffers dut results and packs them two per output word, emitting a partial
// word on flush or idle timeout.
module dout_pair_packer
    import dout_pkg::*;
#(
    parameter int unsigned W       = W_RES,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vld,
    input  logic [W-1:0]   in_data,
    output logic           in_busy,
    input  logic           flush,
    output logic           out_vld,
    output logic [2*W-1:0] out_data,
    output logic [1:0]     out_cnt,
    input  logic           out_busy,
    output logic [15:0]    word_count
);

    localparam int unsigned CTR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    pk_state_t    state;
    logic [W-1:0] lo;
    logic [W-1:0] fifo_dout;
    logic         fifo_empty;
    logic         fifo_full;
    logic         pop_c;
    logic         flush_pend;
    logic [CTR_W-1:0] idle_ctr;
    logic         timeout_hit_c;

    pkr_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_vld),
        .din   (in_data),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_busy       = fifo_full;
    assign timeout_hit_c = (TIMEOUT != 0) && (idle_ctr == CTR_W'(TIMEOUT));

    // The FSM takes a sample whenever it is not blocked by a held output word.
    always_comb begin
        pop_c = 1'b0;
        case (state)
            IDLE, HAVE_ONE: pop_c = !fifo_empty;
            OUT:            pop_c = !out_busy && !fifo_empty;
            default:        pop_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lo         <= '0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_cnt    <= 2'd0;
            word_count <= 16'd0;
            idle_ctr   <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        lo         <= fifo_dout;
                        idle_ctr   <= '0;
                        state      <= HAVE_ONE;
                        flush_pend <= flush_pend || flush;
                    end else begin
                        // Nothing buffered: a pending or fresh flush has no effect.
                        flush_pend <= 1'b0;
                    end
                end
                HAVE_ONE: begin
                    flush_pend <= flush_pend || flush;
                    if (!fifo_empty) begin
                        out_data <= {fifo_dout, lo};
                        out_cnt  <= 2'd2;
                        out_vld  <= 1'b1;
                        idle_ctr <= '0;
                        state    <= OUT;
                    end else if (flush || flush_pend || timeout_hit_c) begin
                        out_data <= {W'(0), lo};
                        out_cnt  <= 2'd1;
                        out_vld  <= 1'b1;
                        state    <= OUT;
                    end else begin
                        idle_ctr <= idle_ctr + CTR_W'(1);
                    end
                end
                OUT: begin
                    if (!out_busy) begin
                        word_count <= word_count + 16'd1;
                        out_vld    <= 1'b0;
                        out_cnt    <= 2'd0;
                        out_data   <= '0;
                        // A delivered partial word consumes the pending flush.
                        flush_pend <= (out_cnt == 2'd1) ? flush : (flush_pend || flush);
                        if (!fifo_empty) begin
                            lo       <= fifo_dout;
                            idle_ctr <= '0;
                            state    <= HAVE_ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        flush_pend <= flush_pend || flush;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dout_pair_packer.sv
// Directed self-checking bench for dout_pair_packer.
module tb_dout_pair_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic [10:0] in_data = '0;
    logic        in_busy;
    logic        flush = 1'b0;
    logic        out_vld;
    logic [21:0] out_data;
    logic [1:0]  out_cnt;
    logic        out_busy = 1'b0;
    logic [15:0] word_count;

    int tests = 0;
    int fails = 0;
    logic [23:0] words [$];
    logic busy_seen = 1'b0;
    logic mon_busy_en = 1'b0;
    int n;

    dout_pair_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .in_busy    (in_busy),
        .flush      (flush),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_cnt    (out_cnt),
        .out_busy   (out_busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Record every output word that will transfer on the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst && out_vld && !out_busy) words.push_back({out_cnt, out_data});
        if (mon_busy_en && in_busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [1:0] cnt,
                               input logic [10:0] hi, input logic [10:0] lo);
        logic [23:0] w;
        logic [23:0] e;
        e = {cnt, hi, lo};
        w = (words.size() > 0) ? words.pop_front() : 24'hFFFFFF;
        check(tag, 32'(w), 32'(e));
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic push(input logic [10:0] d);
        int k;
        k = 0;
        in_vld  = 1'b1;
        in_data = d;
        while (in_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            tests++;
            fails++;
            $error("FAIL push_timeout observed=busy expected=accept data=%0h", d);
        end
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_busy"},    32'(in_busy),    32'd0);
        check({tag, "_out_vld"},    32'(out_vld),    32'd0);
        check({tag, "_out_data"},   32'(out_data),   32'd0);
        check({tag, "_out_cnt"},    32'(out_cnt),    32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back streaming with no backpressure
        mon_busy_en = 1'b1;
        for (int i = 1; i <= 8; i++) push(11'(i));
        repeat (6) @(negedge clk);
        mon_busy_en = 1'b0;
        check("stream_busy_seen", 32'(busy_seen), 32'd0);
        check("stream_nwords", 32'(words.size()), 32'd4);
        expect_word("stream_w0", 2'd2, 11'h002, 11'h001);
        expect_word("stream_w1", 2'd2, 11'h004, 11'h003);
        expect_word("stream_w2", 2'd2, 11'h006, 11'h005);
        expect_word("stream_w3", 2'd2, 11'h008, 11'h007);
        check("stream_word_count", 32'(word_count), 32'd4);

        // Flush of a lone sample: partial word one edge later
        push(11'h123);
        repeat (3) @(negedge clk);
        check("flush_pre_vld", 32'(out_vld), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_vld", 32'(out_vld), 32'd1);
        check("flush_cnt", 32'(out_cnt), 32'd1);
        check("flush_data", 32'(out_data), 32'h0000123);
        @(negedge clk);
        expect_word("flush_word", 2'd1, 11'h000, 11'h123);
        check("flush_word_count", 32'(word_count), 32'd5);

        // Flush with nothing buffered is a no-op; the next lone sample waits for timeout
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("noop_flush_nwords", 32'(words.size()), 32'd0);
        push(11'h0AB);
        n = 0;
        while (!out_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 32'd18);
        @(negedge clk);
        expect_word("timeout_word", 2'd1, 11'h000, 11'h0AB);
        check("timeout_word_count", 32'(word_count), 32'd6);

        // Second sample arriving just before the timeout forms a full pair
        push(11'h055);
        repeat (16) @(negedge clk);
        push(11'h0AA);
        repeat (4) @(negedge clk);
        check("late_pair_nwords", 32'(words.size()), 32'd1);
        expect_word("late_pair_word", 2'd2, 11'h0AA, 11'h055);
        check("late_pair_word_count", 32'(word_count), 32'd7);

        // Backpressure: lo/hi plus DEPTH entries accepted before in_busy
        out_busy = 1'b1;
        push(11'h7FF);
        push(11'h400);
        push(11'h0AA);
        push(11'h155);
        push(11'h3C3);
        check("bp_busy_after5", 32'(in_busy), 32'd0);
        push(11'h001);
        check("bp_busy_after6", 32'(in_busy), 32'd1);
        check("bp_out_vld", 32'(out_vld), 32'd1);
        check("bp_out_data", 32'(out_data), 32'({11'h400, 11'h7FF}));
        check("bp_word_count_hold", 32'(word_count), 32'd7);
        fork
            push(11'h002);
            begin
                repeat (4) @(negedge clk);
                out_busy = 1'b0;
            end
        join
        push(11'h003);
        repeat (8) @(negedge clk);
        check("bp_nwords", 32'(words.size()), 32'd4);
        expect_word("bp_w0", 2'd2, 11'h400, 11'h7FF);
        expect_word("bp_w1", 2'd2, 11'h155, 11'h0AA);
        expect_word("bp_w2", 2'd2, 11'h001, 11'h3C3);
        expect_word("bp_w3", 2'd2, 11'h003, 11'h002);
        check("bp_word_count", 32'(word_count), 32'd11);

        // Flush coincident with the pairing pop: pair first, then flush hits the next lone sample
        push(11'h011);
        push(11'h022);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        push(11'h033);
        repeat (6) @(negedge clk);
        check("cflush_nwords", 32'(words.size()), 32'd2);
        expect_word("cflush_pair", 2'd2, 11'h022, 11'h011);
        expect_word("cflush_partial", 2'd1, 11'h000, 11'h033);
        check("cflush_word_count", 32'(word_count), 32'd13);

        // Reset mid-stream with three samples held
        out_busy = 1'b1;
        push(11'h0C1);
        push(11'h0C2);
        push(11'h0C3);
        check("midrst_pre_vld", 32'(out_vld), 32'd1);
        #1 rst = 1'b1;
        #1 check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        out_busy = 1'b0;
        words.delete();
        @(negedge clk);
        push(11'h0E1);
        push(11'h0E2);
        repeat (5) @(negedge clk);
        check("postrst_nwords", 32'(words.size()), 32'd1);
        expect_word("postrst_word", 2'd2, 11'h0E2, 11'h0E1);
        check("postrst_word_count", 32'(word_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
